// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter feeding a shared 4:1 mux into a one-entry output register
module rr_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);
    logic [1:0]       ptr;
    logic [1:0]       g;
    logic [1:0]       idx;
    logic             any;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    assign any  = |req_valid;
    assign load = !out_valid || out_ready;
    assign take = load && any && !rst;

    // scan from the farthest slot back to the nearest so the slot right after ptr wins and ptr itself ranks last
    always_comb begin
        g   = ptr;
        idx = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) g = idx;
        end
    end

    // shared data mux steered by the grant
    always_comb begin
        sel_data = g == 2'd0 ? req_data0 :
                   g == 2'd1 ? req_data1 :
                   g == 2'd2 ? req_data2 : req_data3;
    end

    // one-hot acceptance strobe, held low during stalls and reset
    always_comb begin
        req_ready = take ? 4'b0001 << g : 4'b0000;
    end

    // output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd3;
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_data <= sel_data;
                out_src  <= g;
                ptr      <= g;
            end
        end
    end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 data mux between four independent requesters and presents the selected word on a single registered output channel. Each requester offers a WIDTH-bit word with a valid/ready handshake. The arbiter chooses the select value each cycle, drives the mux, and captures the result into a one-entry output register. It sits in front of any single-consumer resource that four sources must take turns on.

## Interface
- WIDTH, default 4: data width of every requester word and of the output word.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  bit i set means requester i offers req_data_i this cycle.
- req_data0..req_data3  input  WIDTH each  requester words.
- req_ready  output  4  one-hot or zero; bit i set means requester i's word is accepted at this edge.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data when out_valid is also set.

## Operation
- State: out_valid, out_data, out_src, and a 2-bit pointer ptr holding the last granted index.
- load = !out_valid || out_ready. The output register may take a new word this cycle.
- Grant search: scan ptr+1, ptr+2, ptr+3, ptr+4 (all mod 4). The grant g is the first index with req_valid set.
  - Because the scan ends on ptr itself, the last winner has the lowest priority.
  - Any requester that is continuously valid is served within 4 transfers.
- req_ready[g] = load && any req_valid. All other bits are 0. req_ready is combinational from req_valid, out_valid, out_ready and ptr.
- Mux select = g. The captured word is req_data_g. The mux and the search are combinational inside the block.
- At the edge, when load and any req_valid:
  - out_data <= req_data_g, out_src <= g, out_valid <= 1, ptr <= g.
- At the edge, when load and no req_valid:
  - out_valid <= 0. out_data, out_src and ptr hold.
- At the edge, when !load (out_valid=1 and out_ready=0, stall):
  - All state holds and req_ready = 0.
  - out_data and out_src must not change while the stall lasts.
- Simultaneous events:
  - If the consumer takes a word and a new request arrives in the same cycle, the new word loads in that cycle. Throughput is 1 word/cycle.
  - If a requester drops req_valid while it is not granted, nothing is lost. The block never holds requester words internally.
- Requester contract: once req_valid is asserted, req_valid and req_data stay stable until req_ready. The bench checks this; the block does not.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=3 (requester 0 wins first), req_ready=0.
- Reset during a stall discards the held word. out_valid is 0 in the cycle after reset is asserted.
- req_ready is 0 in every cycle that rst is high.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
- No combinational path from req_data to out_data.
- Combinational paths exist from out_ready and req_valid to req_ready.

## Test plan
- Reset, then req_valid=4'b1111 with data 1,2,3,4 and out_ready=1 held -> out_src sequence 0,1,2,3,0,… and out_data 1,2,3,4,1,…, one word per cycle.
- Only requester 2 valid, data 4'hA, out_ready=1 -> req_ready=4'b0100 every cycle, out_src=2 and out_data=4'hA each cycle.
- Last grant 1, req_valid=4'b0011 -> next grant 0, then 1. This proves the last winner has lowest priority.
- Load word 4'h5 from requester 3, then hold out_ready=0 for 5 cycles with all requesters valid -> out_data=5, out_src=3 and out_valid=1 stay stable, and req_ready=0 throughout. Release out_ready -> grant 0 in that cycle.
- No requests while out_ready=1 -> out_valid falls to 0 after one cycle, and ptr is unchanged; next request from requester 1 with ptr=3 is granted immediately.
- Assert rst during a stall with out_valid=1 -> after the edge out_valid=0 and out_data=0, and the next grant goes to requester 0.
